// File: rtl/conv_encoder_framed.sv
// Framed rate-1/2 convolutional encoder: FRAME_LEN data symbols, then K-1 zero-tail symbols.
// Optional build macro ENC_SCRAMBLE_EN whitens data bits with a 7-bit LFSR before encoding.
module conv_encoder_framed #(
  parameter int             K         = 3,
  parameter logic [K-1:0]   G0        = 3'b111,
  parameter logic [K-1:0]   G1        = 3'b101,
  parameter int             FRAME_LEN = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       ready_o,
  output logic       valid_o,
  output logic [1:0] d_out,
  output logic       frame_start_o,
  output logic       tail_o
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int TW = (K > 2) ? $clog2(K - 1) : 1;

  typedef enum logic {S_DATA, S_TAIL} state_t;

  state_t          state_q, state_d;
  logic [K-2:0]    sr_q, sr_d, sr_shift;
  logic [CW-1:0]   bit_ct_q, bit_ct_d;
  logic [TW-1:0]   tail_ct_q, tail_ct_d;
  logic            first_q, first_d;
  logic            valid_q, valid_d;
  logic [1:0]      dout_q, dout_d;
  logic            fs_q, fs_d;
  logic            tail_q, tail_d;
  logic [K-1:0]    word;
  logic            b;
  logic            accept;
  logic            last_bit;
  logic            tail_done;
`ifdef ENC_SCRAMBLE_EN
  logic [6:0]      lfsr_q, lfsr_d;
`endif

  assign ready_o       = (state_q == S_DATA);
  assign accept        = enable_i && ready_o;
  assign last_bit      = (bit_ct_q == CW'(FRAME_LEN - 1));
  assign tail_done     = (state_q == S_TAIL) && (tail_ct_q == '0);
  assign valid_o       = valid_q;
  assign d_out         = dout_q;
  assign frame_start_o = fs_q;
  assign tail_o        = tail_q;

  // Tail symbols always encode a zero so the trellis is flushed back to state 0.
`ifdef ENC_SCRAMBLE_EN
  assign b = ready_o ? (d_in ^ lfsr_q[6]) : 1'b0;
`else
  assign b = ready_o ? d_in : 1'b0;
`endif

  always_comb begin
    word      = '0;
    word[K-1] = b;
    sr_shift  = '0;
    sr_shift[0] = b;
    for (int i = 0; i < K - 1; i++) word[K-2-i] = sr_q[i];
    for (int i = 1; i < K - 1; i++) sr_shift[i] = sr_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_DATA;
      sr_q      <= '0;
      bit_ct_q  <= '0;
      tail_ct_q <= '0;
      first_q   <= 1'b1;
      valid_q   <= 1'b0;
      dout_q    <= 2'b00;
      fs_q      <= 1'b0;
      tail_q    <= 1'b0;
`ifdef ENC_SCRAMBLE_EN
      lfsr_q    <= 7'h7F;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_ct_q  <= bit_ct_d;
      tail_ct_q <= tail_ct_d;
      first_q   <= first_d;
      valid_q   <= valid_d;
      dout_q    <= dout_d;
      fs_q      <= fs_d;
      tail_q    <= tail_d;
`ifdef ENC_SCRAMBLE_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_DATA) begin
      if (accept && last_bit) state_d = S_TAIL;
    end else begin
      if (tail_done) state_d = S_DATA;
    end
  end

  always_comb begin
    sr_d      = sr_q;
    bit_ct_d  = bit_ct_q;
    tail_ct_d = tail_ct_q;
    first_d   = first_q;
    valid_d   = 1'b0;
    dout_d    = dout_q;
    fs_d      = 1'b0;
    tail_d    = 1'b0;
`ifdef ENC_SCRAMBLE_EN
    lfsr_d    = lfsr_q;
`endif
    if (accept) begin
      valid_d = 1'b1;
      dout_d  = {^(word & G0), ^(word & G1)};
      sr_d    = sr_shift;
      fs_d    = first_q;
      first_d = 1'b0;
`ifdef ENC_SCRAMBLE_EN
      lfsr_d  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[3]};
`endif
      if (last_bit) begin
        bit_ct_d  = '0;
        tail_ct_d = TW'(K - 2);
      end else begin
        bit_ct_d  = bit_ct_q + 1'b1;
      end
    end else if (state_q == S_TAIL) begin
      valid_d = 1'b1;
      tail_d  = 1'b1;
      dout_d  = {^(word & G0), ^(word & G1)};
      sr_d    = sr_shift;
      if (tail_done) begin
        first_d = 1'b1;
`ifdef ENC_SCRAMBLE_EN
        lfsr_d  = 7'h7F;
`endif
      end else begin
        tail_ct_d = tail_ct_q - 1'b1;
      end
    end
  end

endmodule

// File: doc/conv_encoder_framed.md
CONV_ENCODER_FRAMED -- requirements
Module: conv_encoder_framed

Interface
REQ-001 SHALL have parameter K, default 3, constraint length (K >= 2).
REQ-002 SHALL have parameter G0, default 3'b111, K-bit generator polynomial for d_out[1]; bit K-1 taps the current input.
REQ-003 SHALL have parameter G1, default 3'b101, K-bit generator polynomial for d_out[0].
REQ-004 SHALL have parameter FRAME_LEN, default 256, data bits per frame (>= 1).
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port enable_i  input  1  data bit offered this cycle.
REQ-008 SHALL have port d_in  input  1  data bit.
REQ-009 SHALL have port ready_o  output  1  encoder accepts d_in this cycle.
REQ-010 SHALL have port valid_o  output  1  d_out carries a new symbol.
REQ-011 SHALL have port d_out  output  2  encoded symbol {G0 parity, G1 parity}.
REQ-012 SHALL have port frame_start_o  output  1  first symbol of a frame, qualified by valid_o.
REQ-013 SHALL have port tail_o  output  1  current symbol is a termination (tail) symbol, qualified by valid_o.

Function
REQ-014 SHALL hold a (K-1)-bit shift register sr; sr[0] is the most recent accepted bit.
REQ-015 SHALL form the encoder word as {b, sr[0], ..., sr[K-2]}; d_out[1] is the XOR of that word AND G0; d_out[0] is the XOR of that word AND G1.
REQ-016 SHALL implement states DATA and TAIL; ready_o = 1 only in DATA.
REQ-017 DATA: an accept occurs when enable_i && ready_o; on an accept, d_out and valid_o register the symbol for b = d_in, giving latency 1 cycle; sr shifts b in; bit_ct increments.
REQ-018 DATA with enable_i = 0: valid_o = 0 next cycle; d_out holds its last value; sr and bit_ct are unchanged.
REQ-019 On the accept where bit_ct == FRAME_LEN-1: transition to TAIL; ready_o = 0 from the next cycle.
REQ-020 TAIL: each cycle SHALL emit the symbol for b = 0, shift 0 into sr, and set valid_o = 1 and tail_o = 1; this lasts exactly K-1 cycles, then the block returns to DATA with sr = 0 and bit_ct = 0.
REQ-021 In TAIL, enable_i and d_in SHALL be ignored and no data is consumed.
REQ-022 frame_start_o = 1 on the symbol of the first accept after reset or after a TAIL, else 0.
REQ-023 FRAME_LEN = 1: every accept is immediately followed by K-1 tail cycles.
REQ-024 The bit_ct width SHALL be $clog2(FRAME_LEN+1); bit_ct never exceeds FRAME_LEN-1.
REQ-025 Output stream per frame SHALL be exactly FRAME_LEN + K-1 valid symbols, ending in trellis state 0, matching the decoder's zero-start assumption.

Reset
REQ-026 rst = 1 at a clock edge SHALL set state = DATA, sr = 0, bit_ct = 0, valid_o = 0, d_out = 2'b00, frame_start_o = 0, tail_o = 0; ready_o = 1 once rst is low.
REQ-027 rst asserted mid-frame or mid-TAIL SHALL abandon the frame with no further tail symbols; the next accept is a frame start.
REQ-028 rst SHALL take priority over a simultaneous accept.

Configuration
REQ-029 Macro ENC_SCRAMBLE_EN defined: data bits SHALL be scrambled before encoding, b = d_in XOR lfsr[6], using a 7-bit LFSR (x^7+x^4+1) with update lfsr <= {lfsr[5:0], lfsr[6]^lfsr[3]} on each accept; lfsr reloads 7'h7F at reset and on entry to DATA from TAIL; tail bits are not scrambled.
REQ-030 Macro ENC_SCRAMBLE_EN undefined: b = d_in, and no LFSR logic SHALL exist.

Verification
REQ-031 Defaults, no scramble, FRAME_LEN = 4, enable_i held 1, d_in = 1,0,1,1 -> data symbols 11,10,00,01 with frame_start_o on the first; then tail symbols 01,11 with tail_o = 1 and ready_o = 0; the next accept has frame_start_o = 1.
REQ-032 Same stimulus with enable_i deasserted 3 cycles between bits -> identical symbol sequence; valid_o = 0 in the gaps; d_out holds.
REQ-033 FRAME_LEN = 1, d_in = 1 continuously -> repeating pattern 11 (frame_start_o), 10 (tail), 11 (tail), with ready_o low for 2 of every 3 cycles.
REQ-034 rst pulsed after the 2nd data bit of a frame -> valid_o = 0 the cycle after reset; the next accept of d_in = 1 yields 11 with frame_start_o = 1.
REQ-035 ENC_SCRAMBLE_EN, FRAME_LEN = 4, d_in = 0,0,0,0 -> b = 1,1,1,1, symbols 11,01,10,10, tail 01,11; the next frame repeats identically because of the lfsr reload.
REQ-036 FRAME_LEN = 256, random data, 10 frames -> exactly 258 valid symbols per frame, and sr = 0 at the end of each TAIL.
